// File: rtl/alu_param_mc.sv
// alu_param_mc: parameterised ALU with registered results, a WIDTH-cycle
// shift-add unsigned multiplier and a start/busy/done handshake.
module alu_param_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       Aluop,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Rhi,
    output logic             cout,
    output logic             S,
    output logic             V
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0]      acc;
    logic [2*WIDTH-1:0]      acc_nxt;
    logic [WIDTH-1:0]        mcand;
    logic [WIDTH-1:0]        mplier;
    logic [CW-1:0]           count;
    logic [WIDTH:0]          mul_sum;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH:0]          add_sum;
    logic [WIDTH:0]          sub_sum;
    logic [WIDTH-1:0]        res;
    logic                    res_c;
    logic                    res_v;
    logic                    accept;

    // Two's-complement overflow of a + b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Two's-complement overflow of a - b: operands differ in sign, result sign leaves a's.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    assign a_s     = a;
    assign b_s     = b;
    assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign busy    = (state == MUL);
    assign accept  = (state == IDLE) && start;

    // One multiply step: conditionally add the multiplicand into the upper half, then shift right.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nxt = (2*WIDTH)'({mul_sum, acc[WIDTH-1:0]} >> 1);
    end

    // Single-cycle result and flags, evaluated from the live operands at the accept edge.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (Aluop)
            OP_ADD: begin
                res   = add_sum[WIDTH-1:0];
                res_c = add_sum[WIDTH];
                res_v = add_ovf(a[WIDTH-1], b[WIDTH-1], add_sum[WIDTH-1]);
            end
            OP_XOR: res = a ^ b;
            OP_SUB: begin
                res   = sub_sum[WIDTH-1:0];
                res_c = sub_sum[WIDTH];
                res_v = sub_ovf(a[WIDTH-1], b[WIDTH-1], sub_sum[WIDTH-1]);
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_NOR: res = ~(a | b);
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            default: res = '0;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: enter MUL on an accepted multiply, leave after the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && (Aluop == OP_MULT)) state_nxt = MUL;
            MUL:  if (count == LAST)               state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: result registers, done pulse and multiplier working registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            R      <= '0;
            Rhi    <= '0;
            cout   <= 1'b0;
            S      <= 1'b0;
            V      <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (Aluop == OP_MULT) begin
                    acc    <= '0;
                    mcand  <= a;
                    mplier <= b;
                    count  <= '0;
                end else begin
                    R    <= res;
                    Rhi  <= '0;
                    cout <= res_c;
                    S    <= res[WIDTH-1];
                    V    <= res_v;
                    done <= 1'b1;
                end
            end else if (state == MUL) begin
                acc    <= acc_nxt;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (count == LAST) begin
                    R    <= acc_nxt[WIDTH-1:0];
                    Rhi  <= acc_nxt[2*WIDTH-1:WIDTH];
                    cout <= |acc_nxt[2*WIDTH-1:WIDTH];
                    S    <= acc_nxt[WIDTH-1];
                    V    <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_param_mc.sv
// tb_alu_param_mc: directed bench for alu_param_mc at WIDTH=32 and WIDTH=8.
module tb_alu_param_mc;

    logic clk = 1'b0;
    logic reset;

    logic        start32, cin32, busy32, done32, cout32, s32, v32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, r32, rhi32;

    logic        start8, cin8, busy8, done8, cout8, s8, v8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, r8, rhi8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_param_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32),
        .Aluop(op32), .cin(cin32), .busy(busy32), .done(done32),
        .R(r32), .Rhi(rhi32), .cout(cout32), .S(s32), .V(v32)
    );

    alu_param_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .Aluop(op8), .cin(cin8), .busy(busy8), .done(done8),
        .R(r8), .Rhi(rhi8), .cout(cout8), .S(s8), .V(v8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic c);
        op32 = op; a32 = x; b32 = y; cin32 = c; start32 = 1'b1;
        tick();
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                          input logic c);
        op8 = op; a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy32, done32, r32, rhi32, cout32, s32, v32} !== 69'd0) begin
            errors++;
            $display("FAIL reset32 got busy=%b done=%b R=%h Rhi=%h c=%b s=%b v=%b want all 0",
                     busy32, done32, r32, rhi32, cout32, s32, v32);
        end
        checks++;
        if ({busy8, done8, r8, rhi8, cout8, s8, v8} !== 21'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b R=%h Rhi=%h want all 0", busy8, done8, r8, rhi8);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_logic();
        issue32(3'b110, 32'hAAAAAAAA, 32'h55555555, 1'b0);
        checks++;
        if ({done32, r32, cout32, v32, s32} !== {1'b1, 32'h00000000, 3'b000}) begin
            errors++;
            $display("FAIL and1 got done=%b R=%h c=%b v=%b s=%b want 1 00000000 0 0 0",
                     done32, r32, cout32, v32, s32);
        end
        issue32(3'b110, 32'h3E0543DC, 32'h0EA6602A, 1'b1);
        checks++;
        if ({done32, r32, cout32} !== {1'b1, 32'h0E044008, 1'b0}) begin
            errors++;
            $display("FAIL and2 got done=%b R=%h c=%b want 1 0E044008 0", done32, r32, cout32);
        end
        issue32(3'b111, 32'h80000001, 32'h00F00000, 1'b0);
        checks++;
        if ({r32, s32, cout32} !== {32'h80F00001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL or got R=%h s=%b c=%b want 80F00001 1 0", r32, s32, cout32);
        end
        // Done must be a single-cycle pulse; outputs hold.
        tick();
        checks++;
        if ({done32, r32} !== {1'b0, 32'h80F00001}) begin
            errors++;
            $display("FAIL hold got done=%b R=%h want 0 80F00001", done32, r32);
        end
    endtask

    task automatic test_add_sub();
        issue32(3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        checks++;
        if ({r32, v32, s32, cout32} !== {32'h80000000, 3'b110}) begin
            errors++;
            $display("FAIL addovf got R=%h v=%b s=%b c=%b want 80000000 1 1 0", r32, v32, s32, cout32);
        end
        issue32(3'b000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        checks++;
        if ({r32, v32, s32, cout32} !== {32'h00000000, 3'b001}) begin
            errors++;
            $display("FAIL addcin got R=%h v=%b s=%b c=%b want 00000000 0 0 1", r32, v32, s32, cout32);
        end
        issue32(3'b010, 32'h00000000, 32'h00000001, 1'b1);
        checks++;
        if ({r32, cout32, v32, s32} !== {32'hFFFFFFFF, 3'b001}) begin
            errors++;
            $display("FAIL sub got R=%h c=%b v=%b s=%b want FFFFFFFF 0 0 1", r32, cout32, v32, s32);
        end
        issue32(3'b010, 32'h80000000, 32'h00000001, 1'b0);
        checks++;
        if ({r32, cout32, v32, s32} !== {32'h7FFFFFFF, 3'b110}) begin
            errors++;
            $display("FAIL subovf got R=%h c=%b v=%b s=%b want 7FFFFFFF 1 1 0", r32, cout32, v32, s32);
        end
    endtask

    task automatic test_slt();
        issue32(3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        checks++;
        if ({r32, cout32} !== {32'h00000001, 1'b0}) begin
            errors++;
            $display("FAIL slt1 got R=%h c=%b want 00000001 0", r32, cout32);
        end
        issue32(3'b100, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        checks++;
        if (r32 !== 32'h00000000) begin
            errors++;
            $display("FAIL slt2 got R=%h want 00000000", r32);
        end
    endtask

    task automatic test_back_to_back();
        op32 = 3'b001; a32 = 32'hF0F0F0F0; b32 = 32'hFFFF0000; cin32 = 1'b0; start32 = 1'b1;
        tick();
        checks++;
        if ({done32, r32} !== {1'b1, 32'h0F0FF0F0}) begin
            errors++;
            $display("FAIL b2b_xor got done=%b R=%h want 1 0F0FF0F0", done32, r32);
        end
        op32 = 3'b101; a32 = 32'h0; b32 = 32'h0;
        tick();
        start32 = 1'b0;
        checks++;
        if ({done32, r32, s32} !== {1'b1, 32'hFFFFFFFF, 1'b1}) begin
            errors++;
            $display("FAIL b2b_nor got done=%b R=%h s=%b want 1 FFFFFFFF 1", done32, r32, s32);
        end
    endtask

    task automatic test_mult32();
        int first_done = -1;
        int ndone = 0;
        logic [31:0] rr = '0, rh = '0;
        logic cc = 1'b0, bsy_at_done = 1'b1;
        issue32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        checks++;
        if ({busy32, done32} !== 2'b10) begin
            errors++;
            $display("FAIL mult_accept got busy=%b done=%b want 1 0", busy32, done32);
        end
        for (int n = 1; n <= 45; n++) begin
            if (n == 5) begin
                start32 = 1'b1; op32 = 3'b000; a32 = 32'd1; b32 = 32'd1;
            end else begin
                start32 = 1'b0;
            end
            tick();
            if (n == 20) begin
                checks++;
                if (busy32 !== 1'b1) begin
                    errors++;
                    $display("FAIL mult_busy got busy=%b want 1", busy32);
                end
            end
            if (done32 === 1'b1) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = n; rr = r32; rh = rhi32; cc = cout32; bsy_at_done = busy32;
                end
            end
        end
        checks++;
        if (first_done != 32) begin
            errors++;
            $display("FAIL mult_latency got %0d want 32", first_done);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL mult_ignore got %0d done pulses want 1", ndone);
        end
        checks++;
        if ({rh, rr, cc, bsy_at_done} !== {32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mult_result got Rhi=%h R=%h c=%b busy=%b want FFFFFFFE 00000001 1 0",
                     rh, rr, cc, bsy_at_done);
        end
    endtask

    task automatic test_mult8();
        int first_done = -1;
        issue8(3'b011, 8'd13, 8'd11, 1'b0);
        for (int n = 1; n <= 20 && first_done < 0; n++) begin
            tick();
            if (done8 === 1'b1) first_done = n;
        end
        checks++;
        if (first_done != 8) begin
            errors++;
            $display("FAIL mult8_latency got %0d want 8", first_done);
        end
        checks++;
        if ({r8, rhi8, cout8, busy8} !== {8'h8F, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL mult8_result got R=%h Rhi=%h c=%b busy=%b want 8F 00 0 0", r8, rhi8, cout8, busy8);
        end
        // Request in the done cycle must be accepted.
        issue8(3'b111, 8'h0F, 8'h30, 1'b0);
        checks++;
        if ({done8, r8, rhi8, cout8} !== {1'b1, 8'h3F, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mult8_b2b got done=%b R=%h Rhi=%h c=%b want 1 3F 00 0", done8, r8, rhi8, cout8);
        end
        issue8(3'b011, 8'hFF, 8'hFF, 1'b0);
        first_done = -1;
        for (int n = 1; n <= 20 && first_done < 0; n++) begin
            tick();
            if (done8 === 1'b1) first_done = n;
        end
        checks++;
        if ({first_done == 8, r8, rhi8, cout8} !== {1'b1, 8'h01, 8'hFE, 1'b1}) begin
            errors++;
            $display("FAIL mult8_max got lat=%0d R=%h Rhi=%h c=%b want 8 01 FE 1", first_done, r8, rhi8, cout8);
        end
        issue8(3'b010, 8'd3, 8'd5, 1'b0);
        checks++;
        if ({r8, rhi8, cout8, s8, v8} !== {8'hFE, 8'h00, 3'b010}) begin
            errors++;
            $display("FAIL sub8 got R=%h Rhi=%h c=%b s=%b v=%b want FE 00 0 1 0", r8, rhi8, cout8, s8, v8);
        end
    endtask

    task automatic test_reset_mid_mult();
        int ndone = 0;
        issue32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        for (int n = 1; n < 10; n++) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy32, done32, r32, rhi32, cout32, s32, v32} !== 69'd0) begin
            errors++;
            $display("FAIL midreset got busy=%b done=%b R=%h Rhi=%h c=%b s=%b v=%b want all 0",
                     busy32, done32, r32, rhi32, cout32, s32, v32);
        end
        tick();
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done32 === 1'b1 || busy32 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort got %0d cycles with done/busy want 0", ndone);
        end
        issue32(3'b000, 32'd2, 32'd3, 1'b0);
        checks++;
        if ({done32, r32, rhi32} !== {1'b1, 32'd5, 32'd0}) begin
            errors++;
            $display("FAIL post_reset_add got done=%b R=%h Rhi=%h want 1 00000005 00000000", done32, r32, rhi32);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start32 = 1'b0; op32 = 3'b000; a32 = '0; b32 = '0; cin32 = 1'b0;
        start8  = 1'b0; op8  = 3'b000; a8  = '0; b8  = '0; cin8  = 1'b0;
        #1;
        test_reset();
        test_logic();
        test_add_sub();
        test_slt();
        test_back_to_back();
        test_mult32();
        test_mult8();
        test_reset_mid_mult();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
